// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter for the register file write port: ALU results take priority,
// long-latency results drain from a small FIFO, and a scoreboard tracks pending long ops.
module regfile_wb_arbiter #(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        alu_valid,
  input  logic [4:0]  alu_rd,
  input  logic [31:0] alu_data,
  input  logic        lng_valid,
  output logic        lng_ready,
  input  logic [4:0]  lng_rd,
  input  logic [31:0] lng_data,
  input  logic        iss_valid,
  input  logic [4:0]  iss_rd,
  input  logic [4:0]  q_ra1,
  input  logic [4:0]  q_ra2,
  output logic        q_busy1,
  output logic        q_busy2,
  output logic        stall_req,
  output logic        sb_err,
  output logic        we,
  output logic [4:0]  wa,
  output logic [31:0] wd
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int GW = $clog2(STARVE_LIMIT + 1);

  logic [4:0]    fifo_rd   [DEPTH];
  logic [31:0]   fifo_data [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;

  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  logic [4:0]    head_rd;
  logic [31:0]   head_data;

  logic [31:0]   sb;
  logic [31:0]   sb_next;
  logic          sb_err_next;
  logic [GW-1:0] age;
  logic [GW-1:0] age_next;

  assign full      = (count == CW'(DEPTH));
  assign empty     = (count == '0);
  assign lng_ready = !full;
  assign push      = lng_valid && !full;
  assign pop       = !alu_valid && !empty;
  assign head_rd   = fifo_rd[rd_ptr];
  assign head_data = fifo_data[rd_ptr];

  assign q_busy1 = (q_ra1 != 5'd0) && sb[q_ra1];
  assign q_busy2 = (q_ra2 != 5'd0) && sb[q_ra2];

  always_comb begin
    we = 1'b0;
    wa = 5'd0;
    wd = 32'd0;
    if (alu_valid) begin
      we = (alu_rd != 5'd0);
      wa = alu_rd;
      wd = alu_data;
    end else if (!empty) begin
      we = (head_rd != 5'd0);
      wa = head_rd;
      wd = head_data;
    end
  end

  // Clear on pop is applied before set on issue so a same-cycle set wins.
  always_comb begin
    sb_next     = sb;
    sb_err_next = sb_err;
    if (pop) begin
      sb_next[head_rd] = 1'b0;
    end
    if (iss_valid && (iss_rd != 5'd0)) begin
      if (sb[iss_rd]) begin
        sb_err_next = 1'b1;
      end
      sb_next[iss_rd] = 1'b1;
    end
    sb_next[0] = 1'b0;
  end

  always_comb begin
    if (empty || pop) begin
      age_next = '0;
    end else if (age == GW'(STARVE_LIMIT)) begin
      age_next = age;
    end else begin
      age_next = age + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      sb        <= '0;
      sb_err    <= 1'b0;
      age       <= '0;
      stall_req <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push && !pop) begin
        count <= count + 1'b1;
      end else if (pop && !push) begin
        count <= count - 1'b1;
      end
      sb        <= sb_next;
      sb_err    <= sb_err_next;
      age       <= age_next;
      stall_req <= (age_next >= GW'(STARVE_LIMIT));
    end
  end

  // Storage needs no reset; only slots between the pointers are ever read.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_rd[wr_ptr]   <= lng_rd;
      fifo_data[wr_ptr] <= lng_data;
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed scenarios plus random traffic, each cycle
// compared against a queue-based model of the writeback and scoreboard rules.
module tb_regfile_wb_arbiter;

  localparam int DEPTH        = 4;
  localparam int STARVE_LIMIT = 8;

  logic        clk;
  logic        rst;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        lng_valid;
  logic        lng_ready;
  logic [4:0]  lng_rd;
  logic [31:0] lng_data;
  logic        iss_valid;
  logic [4:0]  iss_rd;
  logic [4:0]  q_ra1;
  logic [4:0]  q_ra2;
  logic        q_busy1;
  logic        q_busy2;
  logic        stall_req;
  logic        sb_err;
  logic        we;
  logic [4:0]  wa;
  logic [31:0] wd;

  regfile_wb_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(STARVE_LIMIT)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
    .lng_valid(lng_valid), .lng_ready(lng_ready), .lng_rd(lng_rd), .lng_data(lng_data),
    .iss_valid(iss_valid), .iss_rd(iss_rd),
    .q_ra1(q_ra1), .q_ra2(q_ra2), .q_busy1(q_busy1), .q_busy2(q_busy2),
    .stall_req(stall_req), .sb_err(sb_err),
    .we(we), .wa(wa), .wd(wd)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } ent_t;

  ent_t        m_q[$];
  logic [31:0] m_sb;
  logic        m_err;
  int          m_wait;
  logic        m_stall;

  int n_tests = 0;
  int n_fail  = 0;

  logic [42:0] obs;
  logic [42:0] exp_v;
  assign obs = {lng_ready, q_busy1, q_busy2, stall_req, sb_err, we, wa, wd};

  // Expected outputs for the current inputs and model state.
  function automatic logic [42:0] model_exp();
    logic        e_ready, e_b1, e_b2, e_we;
    logic [4:0]  e_wa;
    logic [31:0] e_wd;
    e_ready = (m_q.size() < DEPTH);
    e_b1    = (q_ra1 != 5'd0) && m_sb[q_ra1];
    e_b2    = (q_ra2 != 5'd0) && m_sb[q_ra2];
    e_we = 1'b0; e_wa = 5'd0; e_wd = 32'd0;
    if (alu_valid) begin
      e_we = (alu_rd != 5'd0); e_wa = alu_rd; e_wd = alu_data;
    end else if (m_q.size() > 0) begin
      e_we = (m_q[0].rd != 5'd0); e_wa = m_q[0].rd; e_wd = m_q[0].data;
    end
    return {e_ready, e_b1, e_b2, m_stall, m_err, e_we, e_wa, e_wd};
  endfunction

  // Advance the model by one clock edge using the inputs held across it.
  task automatic model_clock();
    bit   did_pop, did_push;
    ent_t e;
    if (rst) begin
      m_q.delete(); m_sb = '0; m_err = 1'b0; m_wait = 0; m_stall = 1'b0;
      return;
    end
    did_pop  = !alu_valid && (m_q.size() > 0);
    did_push = lng_valid && (m_q.size() < DEPTH);
    if (m_q.size() == 0 || did_pop) m_wait = 0;
    else if (m_wait < STARVE_LIMIT) m_wait = m_wait + 1;
    m_stall = (m_wait >= STARVE_LIMIT);
    if (iss_valid && iss_rd != 5'd0 && m_sb[iss_rd]) m_err = 1'b1;
    if (did_pop) m_sb[m_q[0].rd] = 1'b0;
    if (iss_valid && iss_rd != 5'd0) m_sb[iss_rd] = 1'b1;
    if (did_pop) void'(m_q.pop_front());
    if (did_push) begin
      e.rd = lng_rd; e.data = lng_data;
      m_q.push_back(e);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_clock();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    alu_valid = 1'b0; alu_rd = 5'd0; alu_data = 32'd0;
    lng_valid = 1'b0; lng_rd = 5'd0; lng_data = 32'd0;
    iss_valid = 1'b0; iss_rd = 5'd0;
    q_ra1 = 5'($urandom_range(0, 31)); q_ra2 = 5'($urandom_range(0, 31));
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    tick();
    tick();
    rst = 1'b0;
    #1;
    n_tests++;
    if (obs !== {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0}) begin
      n_fail++;
      $display("[TB] FAIL reset_idle: got %h expected %h", obs, {1'b1, 5'b0, 5'd0, 32'd0});
    end
    tick();
  endtask

  task automatic test_long_path();
    idle_inputs(); iss_valid = 1'b1; iss_rd = 5'd5; q_ra1 = 5'd5;
    #1; exp_v = model_exp(); n_tests++;
    if (obs !== exp_v) begin n_fail++; $display("[TB] FAIL long_issue: got %h expected %h", obs, exp_v); end
    tick();
    idle_inputs(); q_ra1 = 5'd5; lng_valid = 1'b1; lng_rd = 5'd5; lng_data = 32'hDEADBEEF;
    #1; n_tests++;
    if (q_busy1 !== 1'b1 || we !== 1'b0) begin
      n_fail++; $display("[TB] FAIL long_busy_set: busy=%b we=%b expected busy=1 we=0", q_busy1, we);
    end
    tick();
    idle_inputs(); q_ra1 = 5'd5;
    #1; n_tests++;
    if (we !== 1'b1 || wa !== 5'd5 || wd !== 32'hDEADBEEF || q_busy1 !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL long_write: we=%b wa=%0d wd=%h busy=%b expected 1 5 deadbeef 1", we, wa, wd, q_busy1);
    end
    tick();
    idle_inputs(); q_ra1 = 5'd5;
    #1; n_tests++;
    if (q_busy1 !== 1'b0 || we !== 1'b0) begin
      n_fail++; $display("[TB] FAIL long_busy_clear: busy=%b we=%b expected 0 0", q_busy1, we);
    end
    tick();
  endtask

  task automatic test_alu_priority();
    idle_inputs(); lng_valid = 1'b1; lng_rd = 5'd3; lng_data = 32'h22;
    tick();
    idle_inputs(); alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'h11;
    #1; exp_v = model_exp(); n_tests++;
    if (obs !== exp_v || we !== 1'b1 || wa !== 5'd7 || wd !== 32'h11) begin
      n_fail++; $display("[TB] FAIL alu_wins: got %h expected %h", obs, exp_v);
    end
    tick();
    idle_inputs();
    #1; n_tests++;
    if (we !== 1'b1 || wa !== 5'd3 || wd !== 32'h22) begin
      n_fail++; $display("[TB] FAIL fifo_after_alu: we=%b wa=%0d wd=%h expected 1 3 22", we, wa, wd);
    end
    tick();
    idle_inputs(); alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'h33;
    #1; n_tests++;
    if (we !== 1'b0) begin
      n_fail++; $display("[TB] FAIL alu_x0: we=%b expected 0", we);
    end
    tick();
  endtask

  task automatic test_full_starve();
    for (int i = 0; i < 4 + 10; i++) begin
      idle_inputs();
      alu_valid = 1'b1; alu_rd = 5'($urandom_range(1, 31)); alu_data = $urandom;
      if (i < 5) begin
        lng_valid = 1'b1; lng_rd = 5'(10 + i); lng_data = 32'h1000 + 32'(i);
      end
      #1; exp_v = model_exp(); n_tests++;
      if (obs !== exp_v) begin
        n_fail++; $display("[TB] FAIL fill_cycle%0d: got %h expected %h", i, obs, exp_v);
      end
      if (i == 4) begin
        n_tests++;
        if (lng_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL full_ready: got %b expected 0", lng_ready); end
      end
      tick();
    end
    n_tests++;
    if (stall_req !== 1'b1) begin n_fail++; $display("[TB] FAIL starve_stall: got %b expected 1", stall_req); end
    for (int i = 0; i < 4; i++) begin
      idle_inputs();
      #1; exp_v = model_exp(); n_tests++;
      if (obs !== exp_v || we !== 1'b1 || wa !== 5'(10 + i) || wd !== 32'h1000 + 32'(i)) begin
        n_fail++; $display("[TB] FAIL drain%0d: wa=%0d wd=%h expected %0d %h", i, wa, wd, 10 + i, 32'h1000 + 32'(i));
      end
      tick();
    end
    #1; n_tests++;
    if (stall_req !== 1'b0 || we !== 1'b0 || lng_ready !== 1'b1) begin
      n_fail++; $display("[TB] FAIL drained: stall=%b we=%b ready=%b expected 0 0 1", stall_req, we, lng_ready);
    end
  endtask

  task automatic test_x0_sb_err();
    idle_inputs(); lng_valid = 1'b1; lng_rd = 5'd0; lng_data = 32'h1;
    tick();
    idle_inputs();
    #1; n_tests++;
    if (we !== 1'b0 || lng_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL x0_pop: we=%b expected 0", we); end
    tick();
    idle_inputs(); iss_valid = 1'b1; iss_rd = 5'd9;
    #1; n_tests++;
    if (wa !== 5'd0 || we !== 1'b0) begin n_fail++; $display("[TB] FAIL x0_consumed: wa=%0d we=%b expected 0 0", wa, we); end
    tick();
    idle_inputs(); iss_valid = 1'b1; iss_rd = 5'd9; q_ra2 = 5'd9;
    #1; n_tests++;
    if (sb_err !== 1'b0 || q_busy2 !== 1'b1) begin
      n_fail++; $display("[TB] FAIL sb_first: err=%b busy=%b expected 0 1", sb_err, q_busy2);
    end
    tick();
    for (int i = 0; i < 3; i++) begin
      idle_inputs();
      #1; n_tests++;
      if (sb_err !== 1'b1) begin n_fail++; $display("[TB] FAIL sb_err_sticky%0d: got %b expected 1", i, sb_err); end
      tick();
    end
  endtask

  task automatic test_reset_midflight();
    for (int i = 0; i < 3; i++) begin
      idle_inputs();
      alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 32'h5;
      lng_valid = 1'b1; lng_rd = 5'(20 + i); lng_data = $urandom;
      iss_valid = 1'b1; iss_rd = 5'(20 + i);
      tick();
    end
    idle_inputs(); rst = 1'b1;
    tick();
    rst = 1'b0; idle_inputs(); q_ra1 = 5'd20; q_ra2 = 5'd9;
    #1; exp_v = model_exp(); n_tests++;
    if (obs !== exp_v || we !== 1'b0 || lng_ready !== 1'b1 || q_busy1 !== 1'b0 || q_busy2 !== 1'b0 || sb_err !== 1'b0) begin
      n_fail++; $display("[TB] FAIL reset_midflight: got %h expected %h", obs, exp_v);
    end
    tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 500; i++) begin
      idle_inputs();
      alu_valid = ($urandom_range(0, 99) < (stall_req ? 5 : 40));
      alu_rd    = 5'($urandom_range(0, 31));
      alu_data  = $urandom;
      lng_valid = ($urandom_range(0, 99) < 45);
      lng_rd    = 5'($urandom_range(0, 31));
      lng_data  = $urandom;
      iss_valid = ($urandom_range(0, 99) < 25);
      iss_rd    = 5'($urandom_range(0, 31));
      rst       = ($urandom_range(0, 199) == 0);
      #1; exp_v = model_exp(); n_tests++;
      if (!rst && obs !== exp_v) begin
        n_fail++; $display("[TB] FAIL random%0d: got %h expected %h", i, obs, exp_v);
      end
      tick();
      rst = 1'b0;
    end
  endtask

  initial begin
    m_sb = '0; m_err = 1'b0; m_wait = 0; m_stall = 1'b0;
    rst = 1'b1;
    idle_inputs();
    @(negedge clk);
    test_reset();
    test_long_path();
    test_alu_priority();
    test_full_starve();
    test_x0_sb_err();
    test_reset_midflight();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
